// File: rtl/stream_manager_pkg.sv
// Shared types for the fragmenter slot scheduler: FSM state encoding,
// descriptor field layout and a descriptor sanity helper.
package stream_manager_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_ARM       = 3'd2,
    S_FIRE      = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_RECOVER   = 3'd5
  } state_e;

  localparam int unsigned TS_LSB  = 0;
  localparam int unsigned MSS_LSB = 32;
  localparam int unsigned IFG_LSB = 64;
  localparam int unsigned FIELD_W = 32;
  localparam int unsigned DESC_W  = 96;

  // A zero in any field would stall or confuse the fragmenter.
  function automatic logic desc_ok(input logic [DESC_W-1:0] desc);
    return (desc[TS_LSB +: FIELD_W]  != 32'd0) &&
           (desc[MSS_LSB +: FIELD_W] != 32'd0) &&
           (desc[IFG_LSB +: FIELD_W] != 32'd0);
  endfunction

endpackage

// File: rtl/desc_fifo.sv
// Descriptor FIFO: registered storage, first-word-fall-through head,
// registered ready flag and occupancy level.
module desc_fifo
  import stream_manager_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [DESC_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DESC_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [DESC_W-1:0] mem_q [DEPTH];
  logic [DESC_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              ready_q, ready_d;
  logic              do_push_s, do_pop_s;

  // Next-state for pointers, storage, level and the ready flag.
  always_comb begin
    do_push_s = push_valid && ready_q;
    do_pop_s  = pop && (level_q != LW'(0));
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    level_d = level_q + LW'(do_push_s) - LW'(do_pop_s);
    ready_d = (level_d != LW'(DEPTH));
  end

  // State registers; ready stays low while in reset.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ready_q  <= ready_d;
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign level      = level_q;
  assign push_ready = ready_q;

endmodule

// File: rtl/frag_slot_scheduler.sv
// Pops slot descriptors, drives fragmenter config and a shaped trigger,
// then waits for completion or times out and pulses a fragmenter reset.
module frag_slot_scheduler
  import stream_manager_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ARM_CYCLES = 2,
  parameter int unsigned TRIG_HIGH  = 4,
  parameter int unsigned TIMEOUT    = 1000000,
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic [DESC_W-1:0]             s_desc_tdata,
  input  logic                          s_desc_tvalid,
  output logic                          s_desc_tready,
  input  logic                          enable,
  output logic [31:0]                   frag_transfer_size,
  output logic [31:0]                   frag_mss,
  output logic [31:0]                   frag_ifg,
  output logic                          frag_trigger,
  input  logic                          frag_slot_processed,
  output logic                          frag_rst_n,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [31:0]                   slots_done,
  output logic [31:0]                   slots_dropped,
  output logic [31:0]                   slots_timeout
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic [DESC_W-1:0] head_s;
  logic [LW-1:0]     level_s;
  logic              pop_s;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] tcnt_q, tcnt_d;
  logic        latch_q, latch_d;
  logic        trig_q, trig_d;
  logic        rst_n_q, rst_n_d;
  logic        busy_q, busy_d;
  logic [31:0] ts_q, ts_d, mss_q, mss_d, ifg_q, ifg_d;
  logic [31:0] done_q, done_d, dropped_q, dropped_d, timeout_q, timeout_d;

  desc_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .arst       (arst),
    .push_valid (s_desc_tvalid),
    .push_ready (s_desc_tready),
    .push_data  (s_desc_tdata),
    .pop        (pop_s),
    .head       (head_s),
    .level      (level_s)
  );

  assign pop_s = (state_q == S_IDLE) && enable && (level_s != LW'(0));

  // Slot sequencing: config is captured at pop so it is already visible in LOAD.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tcnt_d    = tcnt_q;
    latch_d   = latch_q;
    trig_d    = trig_q;
    rst_n_d   = rst_n_q;
    ts_d      = ts_q;
    mss_d     = mss_q;
    ifg_d     = ifg_q;
    done_d    = done_q;
    dropped_d = dropped_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (pop_s) begin
          tcnt_d  = 32'd0;
          latch_d = 1'b0;
          if (desc_ok(head_s)) begin
            ts_d    = head_s[TS_LSB +: FIELD_W];
            mss_d   = head_s[MSS_LSB +: FIELD_W];
            ifg_d   = head_s[IFG_LSB +: FIELD_W];
            state_d = S_LOAD;
          end else begin
            dropped_d = dropped_q + 32'd1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        state_d = S_ARM;
        cnt_d   = 32'd0;
      end
      S_ARM: begin
        if (cnt_q == 32'(ARM_CYCLES - 1)) begin
          state_d = S_FIRE;
          cnt_d   = 32'd0;
          trig_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_FIRE: begin
        tcnt_d = tcnt_q + 32'd1;
        if (cnt_q == 32'(TRIG_HIGH - 1)) begin
          trig_d = 1'b0;
          cnt_d  = 32'd0;
          if (latch_q || frag_slot_processed) begin
            done_d  = done_q + 32'd1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT_DONE;
          end
        end else begin
          cnt_d   = cnt_q + 32'd1;
          latch_d = latch_q || frag_slot_processed;
        end
      end
      S_WAIT_DONE: begin
        tcnt_d = tcnt_q + 32'd1;
        // Completion takes priority over a deadline in the same cycle.
        if (frag_slot_processed) begin
          done_d  = done_q + 32'd1;
          state_d = S_IDLE;
        end else if (({1'b0, tcnt_q} + 33'd1) >= 33'(TIMEOUT)) begin
          timeout_d = timeout_q + 32'd1;
          state_d   = S_RECOVER;
          cnt_d     = 32'd0;
          rst_n_d   = 1'b0;
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      S_RECOVER: begin
        if (cnt_q == 32'(RST_CYCLES - 1)) begin
          rst_n_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        trig_d  = 1'b0;
        rst_n_d = 1'b1;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // FSM, counters and registered outputs.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 32'd0;
      tcnt_q    <= 32'd0;
      latch_q   <= 1'b0;
      trig_q    <= 1'b0;
      rst_n_q   <= 1'b1;
      busy_q    <= 1'b0;
      ts_q      <= 32'd0;
      mss_q     <= 32'd0;
      ifg_q     <= 32'd0;
      done_q    <= 32'd0;
      dropped_q <= 32'd0;
      timeout_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tcnt_q    <= tcnt_d;
      latch_q   <= latch_d;
      trig_q    <= trig_d;
      rst_n_q   <= rst_n_d;
      busy_q    <= busy_d;
      ts_q      <= ts_d;
      mss_q     <= mss_d;
      ifg_q     <= ifg_d;
      done_q    <= done_d;
      dropped_q <= dropped_d;
      timeout_q <= timeout_d;
    end
  end

  assign frag_transfer_size = ts_q;
  assign frag_mss           = mss_q;
  assign frag_ifg           = ifg_q;
  assign frag_trigger       = trig_q;
  assign frag_rst_n         = rst_n_q;
  assign busy               = busy_q;
  assign fifo_level         = level_s;
  assign slots_done         = done_q;
  assign slots_dropped      = dropped_q;
  assign slots_timeout      = timeout_q;

endmodule

// File: doc/frag_slot_scheduler.md
# frag_slot_scheduler

Sequences the packet fragmenter slot by slot. Accepts a queue of slot descriptors (transfer size, MSS, inter-frame gap), presents each configuration to the fragmenter, and generates the trigger pulse shape its edge detector requires. It then waits for `slot_processed`, and on a hung slot pulses a fragmenter-reset. It sits between the control plane (descriptor AXI-Stream) and the fragmenter's config/trigger pins.

## Interface
- `FIFO_DEPTH`, 4: descriptor FIFO depth, power of two, 2..16.
- `ARM_CYCLES`, 2: cycles `frag_trigger` is held low before firing.
- `TRIG_HIGH`, 4: cycles `frag_trigger` is held high.
- `TIMEOUT`, 1000000: cycles from trigger rise to the `slot_processed` deadline.
- `RST_CYCLES`, 4: width of the `frag_rst_n` low pulse.

Ports:
- `clk`  in  1  single clock.
- `arst`  in  1  asynchronous, active-low reset.
- `s_desc_tdata`  in  96  descriptor: [31:0] transfer_size, [63:32] mss, [95:64] ifg.
- `s_desc_tvalid` / `s_desc_tready`  in/out  1  descriptor handshake.
- `enable`  in  1  when low, no new descriptor is popped.
- `frag_transfer_size`, `frag_mss`, `frag_ifg`  out  32 each  fragmenter configuration.
- `frag_trigger`  out  1  fragmenter trigger.
- `frag_slot_processed`  in  1  completion pulse from the fragmenter.
- `frag_rst_n`  out  1  active-low fragmenter reset pulse on timeout.
- `busy`  out  1  high in any state other than IDLE.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  descriptors queued.
- `slots_done`, `slots_dropped`, `slots_timeout`  out  32 each  wrapping counters.

## Operation
- Reset values: all outputs 0, except `frag_rst_n`=1. FIFO empty, state IDLE.
- FIFO:
  - `s_desc_tready` = !full.
  - A simultaneous push and pop leaves the level unchanged.
  - A push when full is impossible by handshake.
- Validation at pop: a descriptor with transfer_size==0, mss==0 or ifg==0 is dropped.
  - `slots_dropped`+1.
  - State stays IDLE and the next entry may pop the following cycle.
- State machine:
  - IDLE: if `enable` && !empty → pop the descriptor → LOAD.
  - LOAD: register the `frag_*` config outputs → ARM.
  - ARM: `frag_trigger`=0 for ARM_CYCLES → FIRE.
  - FIRE: `frag_trigger`=1 for TRIG_HIGH cycles → WAIT_DONE, trigger returns to 0.
  - WAIT_DONE: on `frag_slot_processed` → `slots_done`+1 → IDLE.
  - WAIT_DONE: when the timeout counter reaches TIMEOUT → `slots_timeout`+1 → RECOVER.
  - RECOVER: `frag_rst_n`=0 for RST_CYCLES, then 1 → IDLE.
- Timeout counter: 32-bit, cleared on FIFO pop, counts from the first FIRE cycle.
- `frag_slot_processed` seen during FIRE is latched. On FIRE exit, go directly to IDLE with `slots_done`+1.
- `frag_slot_processed` outside FIRE/WAIT_DONE is ignored.
- `frag_slot_processed` coinciding with the timeout compare: completion wins, no timeout is counted.
- `enable` deasserted mid-slot: the current slot completes normally; popping stops afterwards.
- Config outputs hold their value from LOAD until the next LOAD, including through IDLE.
- Counters are 32-bit and wrap at 2^32.

## Timing
- The pop handshake occurs in cycle 0 (IDLE, tvalid already buffered in FIFO).
- Cycle 1: config outputs updated (LOAD).
- Cycles 2..1+ARM_CYCLES: `frag_trigger` low.
- Cycles 2+ARM_CYCLES..1+ARM_CYCLES+TRIG_HIGH: `frag_trigger` high (default: cycles 4..7).
- Config outputs are therefore stable ≥ ARM_CYCLES+1 cycles before the trigger rises.
- `frag_slot_processed` in cycle N (WAIT_DONE) → `slots_done` updated and state IDLE in N+1; the next pop is possible in N+1.
- FIFO latency: a descriptor pushed into an empty FIFO in cycle P is poppable in P+1.
- `arst` asserted mid-slot:
  - Immediate return to the reset values.
  - FIFO contents are discarded.
  - `frag_rst_n` stays 1, because the fragmenter shares the system reset.

## Structure
- The shared package `stream_manager_pkg` holds:
  - State encoding localparams (IDLE, LOAD, ARM, FIRE, WAIT_DONE, RECOVER).
  - Descriptor field offsets (TS_LSB=0, MSS_LSB=32, IFG_LSB=64, DESC_W=96).
- One sub-module, `desc_fifo`: synchronous FIFO with DESC_W width, FIFO_DEPTH depth and a level output.
- The FSM and counters live in the top module.

## Test plan
- Single descriptor {ts=100, mss=10, ifg=5}, `slot_processed` pulsed 20 cycles after the trigger fall:
  - Config outputs valid in cycle 1.
  - `frag_trigger` high exactly in cycles 4..7.
  - `slots_done`=1, `busy` low one cycle after the pulse.
- Four descriptors pushed back-to-back, then a fifth:
  - `s_desc_tready` low while full.
  - The slots are triggered in order with the correct config each time.
  - `fifo_level` sequence: 1, 2, 3, 4.
- Descriptor with mss=0, followed by a valid one:
  - `slots_dropped`=1, no trigger for the first.
  - The second is triggered, with its pop one cycle after the drop.
- TIMEOUT=50 and no `slot_processed`:
  - `frag_rst_n` low for 4 cycles starting 50 cycles after the trigger rise.
  - `slots_timeout`=1, then IDLE.
- `slot_processed` during FIRE, and separately on the same cycle as the timeout compare:
  - `slots_done` incremented, `slots_timeout` unchanged.
- `enable` dropped in WAIT_DONE with 2 descriptors queued:
  - The current slot completes.
  - No further pop until `enable`=1.
- `arst` pulsed in FIRE: all outputs return to their reset values, `fifo_level`=0.
